uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, legal 5..9: payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, legal 1..65535: clk cycles per serial bit.
REQ-003 SHALL have parameter STOP_BITS, default 1, legal 1..2: stop bits per frame.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port P_DATA  input  DATA_W: parallel payload, sampled on acceptance.
REQ-007 SHALL have port DATA_VALID  input  1: payload offered.
REQ-008 SHALL have port PAR_EN  input  1: parity bit inserted when 1, sampled on acceptance.
REQ-009 SHALL have port PAR_TYP  input  1: 0 = even, 1 = odd parity, sampled on acceptance.
REQ-010 SHALL have port READY  output  1: payload slot free; acceptance = DATA_VALID & READY at a rising edge.
REQ-011 SHALL have port TX_OUT  output  1: registered serial line, idle high.
REQ-012 SHALL have port Busy  output  1: registered; 1 while a frame is on the line or a payload is held.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; each non-IDLE state lasts CLKS_PER_BIT cycles per bit, using a 16-bit prescaler counter.
REQ-014 SHALL go IDLE->START on the edge that accepts a payload; TX_OUT = 0 from the next edge (latency 1 cycle).
REQ-015 SHALL send DATA_W data bits LSB first in DATA, bit index counter 0..DATA_W-1.
REQ-016 SHALL go DATA->PARITY if the captured PAR_EN = 1, else DATA->STOP.
REQ-017 SHALL make the parity bit = XOR of the captured data when PAR_TYP = 0, XNOR when PAR_TYP = 1.
REQ-018 SHALL drive TX_OUT = 1 for STOP_BITS*CLKS_PER_BIT cycles in STOP.
REQ-019 SHALL capture P_DATA, PAR_EN and PAR_TYP together on acceptance; later input changes SHALL NOT affect the frame.
REQ-020 SHALL ignore DATA_VALID while READY = 0; no payload lost or duplicated.
REQ-021 SHALL hold TX_OUT = 1, Busy = 0 and READY = 1 in IDLE with no held payload.
REQ-022 SHALL assert Busy on the edge after acceptance and deassert it on the edge leaving STOP to IDLE.

Reset
REQ-023 SHALL, while reset = 0, immediately force TX_OUT = 1, Busy = 0, READY = 1, state IDLE, counters 0, and any held payload discarded.
REQ-024 SHALL, on reset mid-frame, abort the frame with no partial bits after release; the first post-reset acceptance starts a clean frame.

Configuration
REQ-025 SHALL use macro UART_TX_HOLD_EN to compile in a one-entry holding register.
REQ-026 SHALL, with UART_TX_HOLD_EN defined, keep READY = 1 during a frame while the holding register is empty, accepting one payload while transmitting.
REQ-027 SHALL, with UART_TX_HOLD_EN defined, go from the last STOP cycle directly to START when a payload is held, with no idle cycle, and make READY = 1 again on that edge.
REQ-028 SHALL, with UART_TX_HOLD_EN defined, accept a payload offered in the last STOP cycle and transmit it back-to-back.
REQ-029 SHALL, without UART_TX_HOLD_EN, make READY = ~Busy, so at least one IDLE cycle separates frames.

Verification
REQ-030 SHALL check DATA_W=8, CLKS_PER_BIT=1, PAR_EN=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; Busy high 10 cycles.
REQ-031 SHALL check PAR_EN=1, PAR_TYP=0, P_DATA=0x07 -> parity bit 1; PAR_TYP=1 -> parity bit 0; 11-bit frame.
REQ-032 SHALL check CLKS_PER_BIT=4, STOP_BITS=2, DATA_W=5, P_DATA=0x1F -> start low 4 cycles, each data bit 4 cycles, stop high 8 cycles; total 32 cycles.
REQ-033 SHALL check UART_TX_HOLD_EN defined, 0x11 then 0x22 offered with DATA_VALID held -> second accepted mid-frame, READY drops, second start bit on the edge after the first stop; no idle gap.
REQ-034 SHALL check UART_TX_HOLD_EN undefined, same stimulus -> second accepted only in IDLE, one-cycle TX_OUT=1 gap between frames.
REQ-035 SHALL check reset low during DATA bit 3 of 0x00 -> TX_OUT=1, Busy=0, READY=1 immediately; after release line stays high until a new acceptance.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_W bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic              READY,
  output logic              TX_OUT,
  output logic              Busy
);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pen_q, pen_d;
  logic              ptyp_q, ptyp_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              last_tick, last_bit, last_stop;

  assign accept    = DATA_VALID & READY;
  assign last_tick = (cnt_q == 16'(CLKS_PER_BIT - 1));
  assign last_bit  = (idx_q == IDX_W'(DATA_W - 1));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

`ifdef UART_TX_HOLD_EN
  logic              hvld_q, hvld_d;
  logic [DATA_W-1:0] hdata_q, hdata_d;
  logic              hpen_q, hpen_d;
  logic              hptyp_q, hptyp_d;
  logic              frame_end;

  assign frame_end = (state_q == S_STOP) & last_tick & last_stop;
  assign READY     = ~hvld_q;
`else
  assign READY     = ~busy_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
`ifdef UART_TX_HOLD_EN
    hvld_d  = hvld_q;
    hdata_d = hdata_q;
    hpen_d  = hpen_q;
    hptyp_d = hptyp_q;
`endif

    if (state_q != S_IDLE) cnt_d = last_tick ? 16'd0 : cnt_q + 16'd1;

    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_START;
        cnt_d   = 16'd0;
        data_d  = P_DATA;
        pen_d   = PAR_EN;
        ptyp_d  = PAR_TYP;
      end
      S_START: if (last_tick) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: if (last_tick) begin
        if (last_bit) begin
          state_d = pen_q ? S_PAR : S_STOP;
          stop_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_PAR: if (last_tick) begin
        state_d = S_STOP;
        stop_d  = 1'b0;
      end
      S_STOP: if (last_tick) begin
        if (last_stop) state_d = S_IDLE;
        else           stop_d  = stop_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_TX_HOLD_EN
    // A held payload wins at frame end; otherwise one offered in the last stop cycle bypasses the slot.
    if (frame_end && hvld_q) begin
      state_d = S_START;
      data_d  = hdata_q;
      pen_d   = hpen_q;
      ptyp_d  = hptyp_q;
      hvld_d  = 1'b0;
    end else if (frame_end && accept) begin
      state_d = S_START;
      data_d  = P_DATA;
      pen_d   = PAR_EN;
      ptyp_d  = PAR_TYP;
    end else if (accept && state_q != S_IDLE) begin
      hvld_d  = 1'b1;
      hdata_d = P_DATA;
      hpen_d  = PAR_EN;
      hptyp_d = PAR_TYP;
    end
`endif

    // Line and Busy are registered from the next state so they change on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[idx_d];
      S_PAR:   tx_d = (^data_d) ^ ptyp_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
`ifdef UART_TX_HOLD_EN
    busy_d = busy_d | hvld_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hvld_q  <= 1'b0;
      hdata_q <= '0;
      hpen_q  <= 1'b0;
      hptyp_q <= 1'b0;
    end else begin
      hvld_q  <= hvld_d;
      hdata_q <= hdata_d;
      hpen_q  <= hpen_d;
      hptyp_q <= hptyp_d;
    end
  end
`endif

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;
endmodule
